// File: rtl/data_mem_pkg.sv
// Shared encodings and types for the pipelined RV32 data memory.
package data_mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = WORD_W / 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] rdata;
        logic              err;
    } rsp_t;

endpackage

// File: rtl/dmem_align.sv
// Combinational lane steering: store shift/byte enables, load shift/extend, alignment errors.
module dmem_align
    import data_mem_pkg::*;
(
    input  logic [1:0]        size_i,
    input  logic [1:0]        lane_i,
    input  logic              unsigned_i,
    input  logic [WORD_W-1:0] st_data_i,
    input  logic [WORD_W-1:0] ld_word_i,
    output logic [WORD_W-1:0] st_data_c_o,
    output logic [BE_W-1:0]   st_be_c_o,
    output logic [WORD_W-1:0] ld_data_c_o,
    output logic              align_err_c_o
);

    logic [4:0]        shamt;
    logic [WORD_W-1:0] ld_sh;

    assign shamt       = {lane_i, 3'b000};
    assign st_data_c_o = st_data_i << shamt;
    assign ld_sh       = ld_word_i >> shamt;

    always_comb begin
        st_be_c_o     = '0;
        ld_data_c_o   = '0;
        align_err_c_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                st_be_c_o   = BE_W'(4'b0001) << lane_i;
                ld_data_c_o = unsigned_i ? {{(WORD_W-8){1'b0}}, ld_sh[7:0]}
                                         : {{(WORD_W-8){ld_sh[7]}}, ld_sh[7:0]};
            end
            SZ_HALF: begin
                st_be_c_o     = BE_W'(4'b0011) << lane_i;
                ld_data_c_o   = unsigned_i ? {{(WORD_W-16){1'b0}}, ld_sh[15:0]}
                                           : {{(WORD_W-16){ld_sh[15]}}, ld_sh[15:0]};
                align_err_c_o = lane_i[0];
            end
            SZ_WORD: begin
                st_be_c_o     = '1;
                ld_data_c_o   = ld_sh;
                align_err_c_o = (lane_i != 2'b00);
            end
            default: align_err_c_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_pipe.sv
// Pipelined RV32 data memory with post-reset clear sweep and configurable read latency.
module data_mem_pipe
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RESET_CLEAR  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [WORD_W-1:0]     req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [WORD_W-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              ready_q;
    logic              clr_we_c;

    logic [WORD_W-1:0] mem [DEPTH];

    logic              accept_c;
    logic              range_err_c;
    logic              align_err_c;
    logic              req_err_c;
    logic              st_we_c;
    logic [IDX_W-1:0]  idx_c;
    logic [WORD_W-1:0] st_data_c;
    logic [BE_W-1:0]   st_be_c;
    logic [WORD_W-1:0] ld_data_c;
    rsp_t              rsp_c;
    rsp_t              pipe_q [READ_LATENCY];

    assign accept_c    = req_valid_i & ready_q;
    assign idx_c       = req_addr_i[IDX_W+1:2];
    assign range_err_c = (req_addr_i >> 2) >= ADDR_WIDTH'(DEPTH);
    assign req_err_c   = align_err_c | range_err_c;
    assign st_we_c     = accept_c & req_we_i & ~req_err_c;

    dmem_align u_align (
        .size_i        (req_size_i),
        .lane_i        (req_addr_i[1:0]),
        .unsigned_i    (req_unsigned_i),
        .st_data_i     (req_wdata_i),
        .ld_word_i     (mem[idx_c]),
        .st_data_c_o   (st_data_c),
        .st_be_c_o     (st_be_c),
        .ld_data_c_o   (ld_data_c),
        .align_err_c_o (align_err_c)
    );

    // FSM state, clear counter and the registered ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= (RESET_CLEAR != 0) ? INIT : RUN;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we_c  = 1'b0;
        case (state_q)
            INIT: begin
                clr_we_c  = 1'b1;
                clr_cnt_d = clr_cnt_q + IDX_W'(1);
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Array has no reset; the sweep (or a masked store) is the only writer
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[clr_cnt_q] <= '0;
        end else if (st_we_c) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (st_be_c[b]) begin
                    mem[idx_c][8*b +: 8] <= st_data_c[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_c.valid = accept_c;
        rsp_c.rdata = (req_we_i | req_err_c) ? '0 : ld_data_c;
        rsp_c.err   = req_err_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= rsp_c;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = pipe_q[READ_LATENCY-1].valid;
    assign rsp_rdata_o = pipe_q[READ_LATENCY-1].rdata;
    assign rsp_err_o   = pipe_q[READ_LATENCY-1].err;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Scoreboard bench: two instances (clearing/latency 3 and retaining/latency 1) share one stimulus stream.
module tb_data_mem_pipe;

    localparam int DEPTH = 16;
    localparam int LAT0  = 3;
    localparam int LAT1  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_uns = 1'b0;
    logic [31:0] req_wdata = '0;

    logic        rdy0, rv0, re0, rdy1, rv1, re1;
    logic [31:0] rd0, rd1;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        bit          care;
        int          acc;
        int          id;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [7:0]  bm [2][DEPTH*4];
    bit          kn [2][DEPTH*4];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          nid = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_pipe #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .READ_LATENCY(LAT0), .RESET_CLEAR(1)) u_dut_clr (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy0),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_size_i(req_size),
        .req_unsigned_i(req_uns), .req_wdata_i(req_wdata),
        .rsp_valid_o(rv0), .rsp_rdata_o(rd0), .rsp_err_o(re0)
    );

    data_mem_pipe #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .READ_LATENCY(LAT1), .RESET_CLEAR(0)) u_dut_ret (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy1),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_size_i(req_size),
        .req_unsigned_i(req_uns), .req_wdata_i(req_wdata),
        .rsp_valid_o(rv1), .rsp_rdata_o(rd1), .rsp_err_o(re1)
    );

    // Byte-array reference: applies a request and returns its expected response
    function automatic exp_t model(int d, bit we, logic [31:0] addr, logic [1:0] size,
                                   bit uns, logic [31:0] wd);
        exp_t        e;
        int          nb;
        logic [31:0] v;
        e.err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
                (size == 2'd2 && addr % 4 != 0) || ((addr >> 2) >= 32'(DEPTH));
        e.rdata = '0;
        e.care  = 1'b1;
        e.acc   = 0;
        e.id    = 0;
        if (!e.err) begin
            nb = 1 << int'(size);
            if (we) begin
                for (int k = 0; k < nb; k++) begin
                    bm[d][int'(addr) + k] = wd[8*k +: 8];
                    kn[d][int'(addr) + k] = 1'b1;
                end
            end else begin
                v = '0;
                for (int k = 0; k < nb; k++) begin
                    v[8*k +: 8] = bm[d][int'(addr) + k];
                    if (!kn[d][int'(addr) + k]) e.care = 1'b0;
                end
                if (!uns && nb < 4 && v[8*nb-1]) begin
                    for (int b = 8*nb; b < 32; b++) v[b] = 1'b1;
                end
                e.rdata = v;
            end
        end
        return e;
    endfunction

    task automatic issue(bit we, logic [31:0] addr, logic [1:0] size, bit uns, logic [31:0] wd);
        exp_t e0, e1;
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_size = size; req_uns = uns; req_wdata = wd;
        checks++;
        if (!(rdy0 && rdy1)) begin
            errors++;
            $display("FAIL issue_ready req#%0d: got ready=%b/%b, expected 1/1", nid, rdy0, rdy1);
        end
        e0 = model(0, we, addr, size, uns, wd);
        e1 = model(1, we, addr, size, uns, wd);
        e0.acc = cyc + 1; e1.acc = cyc + 1;
        e0.id = nid; e1.id = nid;
        nid++;
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(int d, logic v, logic [31:0] rd, logic er);
        exp_t e;
        int   lat;
        if (!v) return;
        checks++;
        if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            errors++;
            $display("FAIL rsp_unexpected dut%0d: got valid rdata=%h err=%b, expected no response", d, rd, er);
            return;
        end
        e   = (d == 0) ? q0.pop_front() : q1.pop_front();
        lat = (d == 0) ? LAT0 : LAT1;
        if (er !== e.err || (e.care && rd !== e.rdata)) begin
            errors++;
            $display("FAIL rsp_data dut%0d req#%0d: got rdata=%h err=%b, expected rdata=%h err=%b",
                     d, e.id, rd, er, e.rdata, e.err);
        end
        checks++;
        if (cyc != e.acc + lat - 1) begin
            errors++;
            $display("FAIL rsp_latency dut%0d req#%0d: got cycle %0d, expected %0d",
                     d, e.id, cyc, e.acc + lat - 1);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk_rsp(0, rv0, rd0, re0);
                chk_rsp(1, rv1, rd1, re1);
            end
        end
    endtask

    task automatic wait_ready();
        int n0 = 0;
        int n1 = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (n0 == 0 && rdy0) n0 = i;
            if (n1 == 0 && rdy1) n1 = i;
            if (n0 != 0 && n1 != 0) break;
        end
        checks++;
        if (n0 != DEPTH) begin
            errors++;
            $display("FAIL ready_rise_clear: got %0d edges, expected %0d", n0, DEPTH);
        end
        checks++;
        if (n1 != 1) begin
            errors++;
            $display("FAIL ready_rise_retain: got %0d edges, expected 1", n1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        checks++;
        if ({rdy0, rv0, re0, rd0} !== '0) begin
            errors++;
            $display("FAIL reset_outputs dut0: got ready=%b valid=%b err=%b rdata=%h, expected all 0",
                     rdy0, rv0, re0, rd0);
        end
        checks++;
        if ({rdy1, rv1, re1, rd1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs dut1: got ready=%b valid=%b err=%b rdata=%h, expected all 0",
                     rdy1, rv1, re1, rd1);
        end
        for (int b = 0; b < DEPTH*4; b++) begin
            bm[0][b] = 8'h00;
            kn[0][b] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready();
    endtask

    initial begin
        int          r;
        logic [31:0] a;
        logic [1:0]  sz;
        for (int b = 0; b < DEPTH*4; b++) begin
            bm[1][b] = 8'h00;
            kn[1][b] = 1'b0;
        end
        fork
            monitor();
        join_none
        @(posedge clk); #1;
        do_reset();

        // Cleared array reads zero everywhere
        for (int w = 0; w < DEPTH; w++) issue(0, 32'(w * 4), 2'd2, 1'b0, '0);

        // Sub-word loads right after a word store
        issue(1, 32'h10, 2'd2, 1'b0, 32'h8899_AABB);
        issue(0, 32'h13, 2'd0, 1'b0, '0);
        issue(0, 32'h12, 2'd1, 1'b1, '0);
        issue(0, 32'h11, 2'd0, 1'b1, '0);
        issue(0, 32'h10, 2'd1, 1'b0, '0);

        // Byte store merges into an existing word
        issue(1, 32'h20, 2'd2, 1'b0, 32'h1122_3344);
        issue(1, 32'h21, 2'd0, 1'b0, 32'hFFFF_FF5A);
        issue(0, 32'h20, 2'd2, 1'b0, '0);
        issue(1, 32'h26, 2'd1, 1'b0, 32'h0000_BEEF);
        issue(0, 32'h24, 2'd2, 1'b0, '0);

        // Error cases leave the array untouched
        issue(1, 32'h0, 2'd2, 1'b0, 32'h0BAD_F00D);
        issue(0, 32'h03, 2'd1, 1'b0, '0);
        issue(1, 32'(DEPTH * 4), 2'd2, 1'b0, 32'hDEAD_BEEF);
        issue(0, 32'h0, 2'd2, 1'b0, '0);
        issue(0, 32'h10, 2'd3, 1'b0, '0);
        issue(1, 32'h0001_0000, 2'd2, 1'b0, 32'h1234_5678);
        issue(0, 32'h0, 2'd2, 1'b0, '0);
        issue(0, 32'h06, 2'd2, 1'b0, '0);
        idle(4);

        // Four back-to-back loads
        for (int i = 0; i < 4; i++) issue(0, 32'(16 + i * 4), 2'd2, 1'b0, '0);
        idle(5);

        // Fill, then randomized traffic with gaps
        for (int w = 0; w < DEPTH; w++) issue(1, 32'(w * 4), 2'd2, 1'b0, $urandom);
        for (int i = 0; i < 250; i++) begin
            r  = int'($urandom_range(0, 7));
            sz = (r < 7) ? 2'(r % 3) : 2'd3;
            a  = 32'($urandom_range(0, DEPTH * 4 + 7));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            issue(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(5);

        // Reset with two loads in flight
        issue(1, 32'h30, 2'd2, 1'b0, 32'hCAFE_F00D);
        issue(0, 32'h30, 2'd2, 1'b0, '0);
        issue(0, 32'h10, 2'd2, 1'b0, '0);
        do_reset();
        issue(0, 32'h30, 2'd2, 1'b0, '0);
        issue(0, 32'h10, 2'd2, 1'b0, '0);
        issue(0, 32'h22, 2'd1, 1'b0, '0);
        idle(8);

        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d responses outstanding, expected 0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_pipe.md
# data_mem_pipe

Parametrised, pipelined RV32 data memory for the load/store stage. It accepts one request per cycle over a valid/ready handshake and does its own sub-word lane steering: RISC-V sized stores, and loads with sign or zero extension. Read latency is configurable and misaligned or out-of-range accesses are flagged. Instead of an async reset clearing every word, it runs a post-reset clear sweep.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, ≥ 4.
- ADDR_WIDTH, 32: byte-address width.
- READ_LATENCY, 1: cycles from request acceptance to response; legal range 1..4.
- RESET_CLEAR, 1: 1 means run the clear sweep after reset; 0 means array contents survive reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata_i  in  32  store data, right-aligned (the rs2 value).
- rsp_valid_o  out  1  response present for one cycle; there is no backpressure.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  request was misaligned, out of range, or had an illegal size.

## Operation
- A request is accepted at a rising edge where req_valid_i and req_ready_o are both 1.
- Every accepted request produces exactly one response. Responses come back in order.
- Word index is addr >> 2; lane is addr[1:0].
- Error conditions, checked in priority order: size 11; half access with addr[0] = 1; word access with addr[1:0] ≠ 0; word index ≥ DEPTH.
- An errored request does not touch the array and returns rdata = 0, err = 1.
- Stores: wdata is shifted left by 8 × lane. Byte enables are:
  - byte: 4'b0001 << lane
  - half: 4'b0011 << lane
  - word: 4'b1111
- The store commits at the acceptance edge.
- Loads: the word is read at acceptance and shifted right by 8 × lane. The low 8 or 16 bits are then extended according to req_unsigned_i.
- FSM has two states:
  - INIT: req_ready_o = 0. A counter writes 0 to words 0..DEPTH-1, one word per cycle. INIT → RUN after word DEPTH-1 is written.
  - RUN: req_ready_o = 1.
- Reset enters INIT when RESET_CLEAR = 1, otherwise RUN.

## Timing
- Reset values: req_ready_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0. Clear counter = 0. Response pipeline is empty.
- After rst_n deasserts:
  - RESET_CLEAR = 1: req_ready_o rises after DEPTH clk edges.
  - RESET_CLEAR = 0: req_ready_o rises after the first edge.
- Latency: for a request accepted at edge E, rsp_valid_o is high in the cycle following edge E + READ_LATENCY − 1. At READ_LATENCY = 1 this is the cycle right after acceptance.
- Throughput is one request per cycle. The response pipeline is a READ_LATENCY-deep shift of {valid, rdata, err}.
- Read-after-write: a load accepted at the edge after a store to the same word returns the post-store data. Back-to-back accesses do not stall.
- Reset asserted mid-operation: all in-flight responses are dropped and the outputs take their reset values immediately. With RESET_CLEAR = 1 the array is cleared by the following sweep; otherwise it is retained.
- req_valid_i during INIT is ignored. No response is generated for it.

## Structure
- Package data_mem_pkg holds:
  - the size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the word width constant (32);
  - the FSM state enum {INIT, RUN}.
- Sub-module dmem_align is combinational. It handles store shift and byte-enable generation, load shift and extension, and misalignment/size error detection.
- The top level holds the array, the FSM and clear counter, and the latency pipeline.

## Test plan
- Reset with RESET_CLEAR = 1 and DEPTH = 16: req_ready_o stays 0 for 16 edges, then rises. A word load from every address returns 0 with err = 0.
- Store word 0x8899AABB at 0x10, then load byte at 0x13 with signed extension: rsp_rdata_o = 0xFFFFFF88. Load half at 0x12 unsigned: rsp_rdata_o = 0x00008899.
- Store byte 0x5A at 0x21 over a word holding 0x11223344: a word load at 0x20 returns 0x11225A44.
- Half load at 0x03: err = 1, rdata = 0. Word store at DEPTH × 4: err = 1 and a subsequent load confirms the array is unchanged. Size 11: err = 1.
- READ_LATENCY = 3 with four back-to-back loads: responses arrive in consecutive cycles, in order, the first one 3 cycles after acceptance.
- Assert rst_n with two loads in flight: no rsp_valid_o is seen for them. With RESET_CLEAR = 0, previously stored data reads back intact.
